// File: rtl/wb_regfile_if.sv
// Writeback bus between the M/WB register, the register file and decode.
// Master drives writeback controls and read indices; slave returns data.
interface wb_regfile_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
);
   logic              MemtoReg;
   logic              RegWr;
   logic [DATA_W-1:0] Do;
   logic [DATA_W-1:0] ALUout;
   logic [4:0]        Rd;
   logic [4:0]        Ra;
   logic [4:0]        Rb;
   logic [DATA_W-1:0] busA;
   logic [DATA_W-1:0] busB;
   logic [DATA_W-1:0] busW;
   logic [CNT_W-1:0]  wb_count;

   modport master (
      output MemtoReg, RegWr, Do, ALUout, Rd, Ra, Rb,
      input  busA, busB, busW, wb_count
   );

   modport slave (
      input  MemtoReg, RegWr, Do, ALUout, Rd, Ra, Rb,
      output busA, busB, busW, wb_count
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: writeback select, 32x register file, commit counter.
// Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input logic          CLK,
   input logic          Resetn,
   wb_regfile_if.slave  bus
);

   logic [DATA_W-1:0] r_regs [32];
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] w_busW;
   logic              w_commit;
   logic [DATA_W-1:0] w_rdA;
   logic [DATA_W-1:0] w_rdB;

   assign w_busW   = bus.MemtoReg ? bus.Do : bus.ALUout;
   assign w_commit = bus.RegWr && (bus.Rd != 5'd0);

   // Entry 0 is reset but never written, so it holds zero for good.
   always_ff @(posedge CLK or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         r_regs[bus.Rd] <= w_busW;
      end
   end

   always_ff @(posedge CLK or negedge Resetn) begin
      if (!Resetn) begin
         r_cnt <= '0;
      end else if (w_commit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_rdA = '0;
      w_rdB = '0;
      if (bus.Ra != 5'd0) begin
         w_rdA = r_regs[bus.Ra];
      end
      if (bus.Rb != 5'd0) begin
         w_rdB = r_regs[bus.Rb];
      end
`ifdef WB_BYPASS_EN
      if (w_commit && (bus.Ra == bus.Rd)) begin
         w_rdA = w_busW;
      end
      if (w_commit && (bus.Rb == bus.Rd)) begin
         w_rdB = w_busW;
      end
`endif
   end

   assign bus.busA     = w_rdA;
   assign bus.busB     = w_rdB;
   assign bus.busW     = w_busW;
   assign bus.wb_count = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array model.
// A second instance with CNT_W=4 shares stimulus to check counter wrap.
module tb_wb_regfile;

   logic CLK;
   logic Resetn;

   wb_regfile_if #(.DATA_W(32), .CNT_W(32)) bus ();
   wb_regfile_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

   wb_regfile #(.DATA_W(32), .CNT_W(32)) u_dut (
      .CLK    (CLK),
      .Resetn (Resetn),
      .bus    (bus.slave)
   );

   wb_regfile #(.DATA_W(32), .CNT_W(4)) u_dut4 (
      .CLK    (CLK),
      .Resetn (Resetn),
      .bus    (bus4.slave)
   );

   assign bus4.MemtoReg = bus.MemtoReg;
   assign bus4.RegWr    = bus.RegWr;
   assign bus4.Do       = bus.Do;
   assign bus4.ALUout   = bus.ALUout;
   assign bus4.Rd       = bus.Rd;
   assign bus4.Ra       = bus.Ra;
   assign bus4.Rb       = bus.Rb;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
   endtask

   function automatic logic [31:0] pre_rd(input logic [4:0] idx,
                                          input logic wr,
                                          input logic [4:0] rd,
                                          input logic [31:0] w);
      if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
      if (wr && rd != 5'd0 && idx == rd) return w;
`endif
      return m_regs[idx];
   endfunction

   task automatic cyc(input logic mr, input logic wr,
                      input logic [31:0] d, input logic [31:0] a,
                      input logic [4:0] rd, input logic [4:0] ra,
                      input logic [4:0] rb);
      logic [31:0] w;
      @(negedge CLK);
      bus.MemtoReg = mr;
      bus.RegWr    = wr;
      bus.Do       = d;
      bus.ALUout   = a;
      bus.Rd       = rd;
      bus.Ra       = ra;
      bus.Rb       = rb;
      w = mr ? d : a;
      #1;
      chk("busW", bus.busW, w);
      chk("preA", bus.busA, pre_rd(ra, wr, rd, w));
      chk("preB", bus.busB, pre_rd(rb, wr, rd, w));
      @(posedge CLK);
      if (wr && rd != 5'd0) begin
         m_regs[rd] = w;
         m_cnt      = m_cnt + 1;
      end
      #1;
      chk("postA", bus.busA, m_regs[ra]);
      chk("postB", bus.busB, m_regs[rb]);
      chk("cnt", bus.wb_count, m_cnt);
      chk("cnt4", {28'd0, bus4.wb_count}, m_cnt & 32'hF);
   endtask

   // Reset asserted mid-cycle, released on a falling edge.
   task automatic rst_mid();
      @(posedge CLK);
      #3;
      bus.RegWr = 1'b0;
      Resetn    = 1'b0;
      m_clear();
      #1;
      chk("rst_busA", bus.busA, 32'd0);
      chk("rst_busB", bus.busB, 32'd0);
      chk("rst_cnt", bus.wb_count, 32'd0);
      @(negedge CLK);
      Resetn = 1'b1;
   endtask

   initial begin
      logic [4:0]  rd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      Resetn       = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.RegWr    = 1'b0;
      bus.Do       = '0;
      bus.ALUout   = '0;
      bus.Rd       = '0;
      bus.Ra       = 5'd5;
      bus.Rb       = 5'd0;
      m_clear();
      #12;
      chk("init_busA", bus.busA, 32'd0);
      chk("init_cnt", bus.wb_count, 32'd0);
      @(negedge CLK);
      Resetn = 1'b1;

      cyc(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
      chk("r5_written", bus.busA, 32'hDEADBEEF);
      rst_mid();

      cyc(1'b1, 1'b1, 32'h12345678, 32'hAAAAAAAA, 5'd7, 5'd7, 5'd0);
      chk("sel_do", bus.busA, 32'h12345678);
      cyc(1'b0, 1'b1, 32'h12345678, 32'hAAAAAAAA, 5'd8, 5'd7, 5'd8);
      chk("sel_alu", bus.busB, 32'hAAAAAAAA);
      chk("cnt_two", bus.wb_count, 32'd2);

      cyc(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
      chk("r0_zero", bus.busA, 32'd0);
      chk("r0_nocnt", bus.wb_count, 32'd2);
      cyc(1'b0, 1'b0, 32'h0, 32'h55555555, 5'd9, 5'd9, 5'd9);
      chk("r9_kept", bus.busA, 32'd0);

      cyc(1'b0, 1'b1, 32'h0, 32'h11, 5'd3, 5'd1, 5'd2);
      cyc(1'b0, 1'b1, 32'h0, 32'h22, 5'd3, 5'd3, 5'd3);
      chk("haz_A", bus.busA, 32'h22);
      chk("haz_B", bus.busB, 32'h22);

      rst_mid();
      for (int i = 0; i < 17; i++) begin
         cyc(1'b0, 1'b1, 32'h0, $urandom, 5'd1, 5'd1, 5'd2);
      end
      chk("wrap4", {28'd0, bus4.wb_count}, 32'd1);

      rst_mid();
      for (int i = 1; i < 32; i++) begin
         cyc(1'b1, 1'b1, i * 32'h01010101, $urandom, 5'(i), 5'(i), 5'd0);
      end
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 1'b0, $urandom, $urandom, 5'(i), 5'(i), 5'(31 - i));
         chk("sweepA", bus.busA, i * 32'h01010101);
         chk("sweepB", bus.busB, (31 - i) * 32'h01010101);
      end
      chk("sweep_cnt", bus.wb_count, 32'd31);

      for (int i = 0; i < 300; i++) begin
         rd = 5'($urandom_range(0, 31));
         ra = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         cyc(1'($urandom), 1'($urandom_range(0, 3) != 0),
             $urandom, $urandom, rd, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
